// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_pkg
// Brief    : ALU operation encodings shared with the decoder, plus shift helpers
// Revision : 1.0
// ============================================================================
package alu_exec_unit_pkg;

    localparam logic [3:0] ALUADD  = 4'h0;
    localparam logic [3:0] ALUSUB  = 4'h1;
    localparam logic [3:0] ALUXOR  = 4'h2;
    localparam logic [3:0] ALUOR   = 4'h3;
    localparam logic [3:0] ALUAND  = 4'h4;
    localparam logic [3:0] ALUSLL  = 4'h5;
    localparam logic [3:0] ALUSRL  = 4'h6;
    localparam logic [3:0] ALUSRA  = 4'h7;
    localparam logic [3:0] ALUSLT  = 4'h8;
    localparam logic [3:0] ALUSLTU = 4'h9;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALUSLL) || (op == ALUSRL) || (op == ALUSRA);
    endfunction

    function automatic logic [1:0] shift_kind(input logic [3:0] op);
        case (op)
            ALUSRL:  return SH_SRL;
            ALUSRA:  return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shifter_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_shifter_iter
// Brief    : One-bit-per-cycle shifter; loads on start_i, shifts while cnt != 0
// Revision : 1.0
// ============================================================================
module alu_shifter_iter
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHWIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHWIDTH-1:0] shamt_i,
    output logic [WIDTH-1:0]   next_o,
    output logic               last_o
);

    logic [WIDTH-1:0]   sh_q;
    logic [SHWIDTH-1:0] cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   sh_d;

    always_comb begin
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
        case (op_q)
            SH_SRL:  sh_d = {1'b0, sh_q[WIDTH-1:1]};
            SH_SRA:  sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_d = {sh_q[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            op_q  <= SH_SLL;
        end else if (start_i) begin
            sh_q  <= data_i;
            cnt_q <= shamt_i;
            op_q  <= op_i;
        end else if (cnt_q != '0) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The edge on which last_o is high performs the final shift
    assign next_o = sh_d;
    assign last_o = (cnt_q == {{(SHWIDTH-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU with valid/ready handshakes and iterative shifts
// Revision : 1.0
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AWIDTH  = 4,
    parameter int SHWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] aluop,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   alu_d;
    logic               accept;
    logic               shift_op;
    logic [SHWIDTH-1:0] shamt;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_last;

    assign accept   = in_valid && (state_q == S_IDLE);
    assign shift_op = is_shift_op(aluop);
    assign shamt    = b[SHWIDTH-1:0];

    // Undefined codes fall through to ADD
    always_comb begin
        alu_d = a + b;
        case (aluop)
            ALUSUB:  alu_d = a - b;
            ALUXOR:  alu_d = a ^ b;
            ALUOR:   alu_d = a | b;
            ALUAND:  alu_d = a & b;
            ALUSLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUSLTU: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_d = a + b;
        endcase
    end

    alu_shifter_iter #(
        .WIDTH   (WIDTH),
        .SHWIDTH (SHWIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && shift_op),
        .op_i    (shift_kind(aluop)),
        .data_i  (a),
        .shamt_i (shamt),
        .next_o  (sh_next),
        .last_o  (sh_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!shift_op) begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            state_q  <= S_DONE;
                        end else if (shamt == '0) begin
                            result_q <= a;
                            zero_q   <= (a == '0);
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sh_last) begin
                        result_q <= sh_next;
                        zero_q   <= (sh_next == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit aluop from the ALU operation decoder plus two operands, and produces a registered result and zero flag.
- Add, sub, logic and compare ops complete in one cycle.
- Shifts use an iterative 1-bit-per-cycle shifter to keep area small.
- Valid/ready handshakes on both sides, so the unit can sit between decode and writeback and stall the pipeline during long shifts.

Parameters:
- WIDTH, 32, operand/result width
- AWIDTH, 4, aluop width; must match the ALU operation decoder
- SHWIDTH, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and aluop valid
- in_ready  out  1  unit can accept a new operation
- aluop  in  AWIDTH  operation code, encodings from alu_defines.v
- a  in  WIDTH  operand A (rs1)
- b  in  WIDTH  operand B (rs2 or immediate); b[SHWIDTH-1:0] is the shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered alongside result
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, result=0, zero=0, out_valid=0, busy=0, shift counter=0. Applies mid-shift or while holding a result: the operation is aborted and discarded, with no out_valid pulse.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). An input is accepted on a posedge with in_valid && in_ready.
- IDLE, accept, non-shift op: compute combinationally and register the result; go to DONE. out_valid rises the next cycle (latency 1).
  - ADD: a+b, mod 2^WIDTH, carry discarded.
  - SUB: a-b, mod 2^WIDTH.
  - XOR, OR, AND: bitwise.
  - SLT: signed a<b gives 1, else 0, zero-extended.
  - SLTU: unsigned compare, same result format.
  - Undefined aluop codes behave as ADD.
- IDLE, accept, shift op (SLL/SRL/SRA): latch the operand into the shift register, latch the op, and set cnt = b[SHWIDTH-1:0].
  - cnt==0: go straight to DONE with result=a (latency 1).
  - Otherwise go to SHIFT.
- SHIFT, each cycle: shift by 1 and decrement cnt.
  - SLL fills with 0; SRL fills the MSB with 0; SRA replicates the MSB.
  - When cnt reaches 0 after the shift, go to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles (shamt=31 gives 32 cycles).
- DONE: out_valid=1; result and zero stay stable until handshake. On out_ready, go to IDLE and drop out_valid the next cycle. No new accept is possible in DONE, so back-to-back throughput is one op per 2 cycles minimum.
- zero is updated in the same cycle as result.
- Inputs a, b and aluop are ignored when not accepted; changes after acceptance do not affect the in-flight op.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Op encodings (ALUADD, ALUSUB, ALUXOR, ALUOR, ALUAND, ALUSLL, ALUSRL, ALUSRA, ALUSLT, ALUSLTU) stay in the shared alu_defines.v.
- State encodings are local parameters.
- One sub-module: alu_shifter_iter, holding the shift register, counter and fill logic, with a start/done interface. The combinational single-cycle ops stay inline.

Test Plan:
- ADD: a=0xFFFFFFFF, b=1, aluop=ALUADD -> out_valid one cycle after accept, result=0, zero=1.
- SUB/SLT: a=5, b=7, ALUSUB -> result=0xFFFFFFFE, zero=0. Then ALUSLT with a=0xFFFFFFFF, b=1 -> 1; ALUSLTU with the same operands -> 0.
- SRA: a=0x80000000, b=4, ALUSRA -> in_ready low for 5 cycles, then result=0xF8000000 with out_valid high on cycle 5. Same operands with ALUSRL -> 0x08000000.
- Shift boundaries: SLL with b=0 -> result=a after 1 cycle. SLL a=1, b=31 -> 0x80000000 after 32 cycles. b=0x25 uses shamt 5 only.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid, result and zero stay constant and in_ready stays 0. Raise out_ready -> IDLE next cycle, and a new op is accepted.
- Reset mid-shift: rst=1 on the third cycle of an SLL by 20 -> next cycle state=IDLE, out_valid=0, result=0, in_ready=1. No stale result appears afterwards.
